alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the team's combinational 8-bit datapath ALU. It widens the datapath to W bits and adds a 3-bit opcode space with subtract, XOR, and variable-amount rotate/shift. Variable shifts execute iteratively, one bit per cycle, behind a start/busy/done handshake. It sits between the register file and writeback. Results and flags are registered and held until the next operation completes.

Parameters:
W, 8, datapath width; power of two, 4 to 64.
SA_W, $clog2(W), shift-amount width, derived; not overridden.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
start_i  in  1  operation request; accepted only when busy_o=0
cmd_i  in  3  opcode: 000 NAND, 001 ROR, 010 ADD, 011 PASS, 100 SUB, 101 ROL, 110 XOR, 111 LSR
a_i  in  W  operand A
b_i  in  W  operand B; for shift ops, the amount is k = b_i[SA_W-1:0]
sc_i  in  1  shift/carry in
busy_o  out  1  high while in SHIFT state
done_o  out  1  one-cycle pulse; rslt_o and flags updated in the same cycle
rslt_o  out  W  result, held between completions
sc_o  out  1  carry/borrow/shift-out, held
zero_o  out  1  rslt_o == 0, held
pari_o  out  1  ^rslt_o, held
neq_o  out  1  captured A != captured B, held

Behaviour:
- Reset: on a clk edge with reset_n=0, state goes to IDLE and count to 0. All outputs become 0, including zero_o. start_i is ignored during reset. Reset in any state, including mid-SHIFT, aborts the operation with no done_o.
- States and transitions:
  - IDLE -> DONE: start_i with a single-cycle op, or a shift op with k=0.
  - IDLE -> SHIFT: start_i with a shift op and k>0.
  - SHIFT -> SHIFT: while count > 1; count decrements each cycle.
  - SHIFT -> DONE: when count = 1 and that last step completes.
  - DONE: accepts start_i exactly like IDLE (back-to-back ops). Otherwise it returns to IDLE.
- Operand capture: on an accepted start, cmd_i, a_i, b_i and sc_i are captured. Inputs are don't-care afterwards.
- busy_o = (state == SHIFT). start_i during SHIFT is ignored, not queued.
- Latency, with start accepted at edge N:
  - single-cycle op: done_o high in the cycle after edge N+1.
  - shift op: done_o high after edge N+1+k.
- done_o is high exactly while in DONE. rslt_o and flags change only on the edge entering DONE. The working register is internal, so rslt_o does not toggle during SHIFT.
- Arithmetic, modulo 2^W:
  - ADD: {sc_o, rslt} = A + B + sc.
  - SUB: rslt = A - B; sc_o = 1 if A < B (unsigned borrow). sc is not used.
  - NAND, XOR, PASS(=A): sc_o = 0.
- Shift ops, one bit per SHIFT cycle on working register R (loaded with A):
  - ROR: R = {R[0], R[W-1:1]}.
  - ROL: R = {R[W-2:0], R[W-1]}.
  - LSR: R = {c, R[W-1:1]}, where c starts at the captured sc; after each step c = the bit shifted out, so the carry chains.
  - sc_o = the bit shifted out on the final step (LSB for ROR/LSR, MSB for ROL).
  - k=0: rslt = A; sc_o = 0 for ROR/ROL, sc_o = captured sc for LSR.
- k is taken modulo W by construction. For W=8, b=0x0B gives k=3; the upper bits of b are ignored.
- Flags are computed from the final result: zero_o = (rslt==0), pari_o = ^rslt, neq_o = (A != B) on the captured operands, for every opcode.

Test Plan:
- W=8, ADD a=0xF0 b=0x20 sc_i=1 -> done_o exactly 1 cycle after start. Expect rslt_o=0x11, sc_o=1, zero_o=0, pari_o=0, neq_o=1, busy_o never high.
- LSR a=0x0F b=0x02 sc_i=1 -> busy_o high 2 cycles, done_o at N+3. Expect rslt_o=0xC3, sc_o=1. rslt_o keeps its old value while busy.
- ROL a=0x81 b=0x09 (k=1) -> rslt_o=0x03, sc_o=1. ROR a=0x81 b=0x0B (k=3) -> rslt_o=0x30, sc_o=0, done_o at N+4.
- SUB a=0x05 b=0x05 -> rslt_o=0x00, zero_o=1, sc_o=0, neq_o=0. Then SUB a=0x03 b=0x05 -> rslt_o=0xFE, sc_o=1, pari_o=1.
- Pulse start_i (cmd XOR) while busy_o=1 -> ignored; the shift result is unaffected. start_i asserted in the done_o cycle -> accepted, next done_o one cycle later. ROR with k=0 -> rslt_o=A, latency 1.
- reset_n=0 for one edge mid-SHIFT -> next cycle all outputs are 0, state IDLE, no done_o. A new ADD afterwards completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle W-bit ALU: single-cycle logic/arith ops, iterative one-bit-per-cycle shifts.
// Results and flags update only on entry to DONE and hold until the next completion.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic [2:0]   cmd_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sc_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] rslt_o,
  output logic         sc_o,
  output logic         zero_o,
  output logic         pari_o,
  output logic         neq_o
);
  localparam int SA_W = $clog2(W);
  localparam logic [SA_W-1:0] CNT_ONE = {{(SA_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_ROR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_LSR  = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [SA_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [W-1:0]    r_q;
  logic            c_q;
  logic            neq_cap_q;
  logic [W-1:0]    rslt_q;
  logic            sc_q, zero_q, pari_q, neq_q, done_q, busy_q;

  logic [SA_W-1:0] k;
  logic            is_shift;
  logic [W:0]      sum, diff;
  logic [W-1:0]    op_rslt_d;
  logic            op_c_d;
  logic [W-1:0]    step_r_d;
  logic            step_out_d;

  assign k        = b_i[SA_W-1:0];
  assign is_shift = (cmd_i == OP_ROR) || (cmd_i == OP_ROL) || (cmd_i == OP_LSR);
  assign sum      = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, sc_i};
  assign diff     = {1'b0, a_i} - {1'b0, b_i};

  // Single-cycle result; shift ops land here only when k == 0.
  always_comb begin
    op_rslt_d = a_i;
    op_c_d    = 1'b0;
    case (cmd_i)
      OP_NAND: op_rslt_d = ~(a_i & b_i);
      OP_ADD:  begin op_rslt_d = sum[W-1:0];  op_c_d = sum[W];  end
      OP_SUB:  begin op_rslt_d = diff[W-1:0]; op_c_d = diff[W]; end
      OP_XOR:  op_rslt_d = a_i ^ b_i;
      OP_LSR:  op_c_d = sc_i;
      default: op_rslt_d = a_i;
    endcase
  end

  always_comb begin
    step_r_d   = {r_q[0], r_q[W-1:1]};
    step_out_d = r_q[0];
    case (op_q)
      OP_ROL:  begin step_r_d = {r_q[W-2:0], r_q[W-1]}; step_out_d = r_q[W-1]; end
      OP_LSR:  step_r_d = {c_q, r_q[W-1:1]};
      default: step_r_d = {r_q[0], r_q[W-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      r_q       <= '0;
      c_q       <= 1'b0;
      neq_cap_q <= 1'b0;
      rslt_q    <= '0;
      sc_q      <= 1'b0;
      zero_q    <= 1'b0;
      pari_q    <= 1'b0;
      neq_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            op_q      <= cmd_i;
            neq_cap_q <= (a_i != b_i);
            if (is_shift && (k != '0)) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
              cnt_q   <= k;
              r_q     <= a_i;
              c_q     <= (cmd_i == OP_LSR) ? sc_i : 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              rslt_q  <= op_rslt_d;
              sc_q    <= op_c_d;
              zero_q  <= (op_rslt_d == '0);
              pari_q  <= ^op_rslt_d;
              neq_q   <= (a_i != b_i);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          r_q   <= step_r_d;
          c_q   <= step_out_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rslt_q  <= step_r_d;
            sc_q    <= step_out_d;
            zero_q  <= (step_r_d == '0);
            pari_q  <= ^step_r_d;
            neq_q   <= neq_cap_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign rslt_o = rslt_q;
  assign sc_o   = sc_q;
  assign zero_o = zero_q;
  assign pari_o = pari_q;
  assign neq_o  = neq_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=8; inputs driven and outputs sampled on the falling edge.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_i;
  logic [2:0] cmd_i;
  logic [7:0] a_i, b_i;
  logic       sc_i;
  logic       busy_o, done_o, sc_o, zero_o, pari_o, neq_o;
  logic [7:0] rslt_o;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] NAND = 3'b000, ROR = 3'b001, ADD = 3'b010, PASS = 3'b011;
  localparam logic [2:0] SUB = 3'b100, ROL = 3'b101, XOR = 3'b110, LSR = 3'b111;

  alu_seq #(.W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .cmd_i(cmd_i),
    .a_i(a_i), .b_i(b_i), .sc_i(sc_i), .busy_o(busy_o), .done_o(done_o),
    .rslt_o(rslt_o), .sc_o(sc_o), .zero_o(zero_o), .pari_o(pari_o), .neq_o(neq_o)
  );

  always #5 clk = ~clk;

  // Present one request for one rising edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b, input logic s);
    cmd_i = c; a_i = a; b_i = b; sc_i = s; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cmd_i = NAND; a_i = 8'hAA; b_i = 8'h55; sc_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_i = 1'b1; cmd_i = PASS; a_i = 8'hFF; b_i = 8'h00; sc_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    checks++; if (rslt_o !== 8'h00) begin failures++; $display("FAIL reset_rslt got=%h exp=00", rslt_o); end
    checks++; if ({busy_o, done_o, sc_o, zero_o, pari_o, neq_o} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {busy_o, done_o, sc_o, zero_o, pari_o, neq_o});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_no_done got=%b exp=0", done_o); end
  endtask

  task automatic test_add();
    int cyc; logic busy_seen;
    busy_seen = 1'b0;
    issue(ADD, 8'hF0, 8'h20, 1'b1);
    cyc = 1;
    while (!done_o && cyc < 20) begin busy_seen |= busy_o; @(negedge clk); cyc++; end
    busy_seen |= busy_o;
    checks++; if (cyc !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", cyc); end
    checks++; if (rslt_o !== 8'h11) begin failures++; $display("FAIL add_rslt got=%h exp=11", rslt_o); end
    checks++; if ({sc_o, zero_o, pari_o, neq_o} !== 4'b1001) begin
      failures++; $display("FAIL add_flags got=%b exp=1001", {sc_o, zero_o, pari_o, neq_o});
    end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", busy_seen); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", done_o); end
  endtask

  task automatic test_lsr();
    int cyc, busy_cnt; logic held_ok;
    busy_cnt = 0; held_ok = 1'b1;
    issue(LSR, 8'h0F, 8'h02, 1'b1);
    cyc = 1;
    while (!done_o && cyc < 20) begin
      if (busy_o) busy_cnt++;
      if (rslt_o !== 8'h11) held_ok = 1'b0;
      @(negedge clk); cyc++;
    end
    checks++; if (cyc !== 3) begin failures++; $display("FAIL lsr_latency got=%0d exp=3", cyc); end
    checks++; if (busy_cnt !== 2) begin failures++; $display("FAIL lsr_busy_cycles got=%0d exp=2", busy_cnt); end
    checks++; if (held_ok !== 1'b1) begin failures++; $display("FAIL lsr_rslt_held got=%b exp=1", held_ok); end
    checks++; if ({rslt_o, sc_o} !== {8'hC3, 1'b1}) begin
      failures++; $display("FAIL lsr_rslt got=%h/%b exp=c3/1", rslt_o, sc_o);
    end
  endtask

  task automatic test_rotate();
    int cyc;
    issue(ROL, 8'h81, 8'h09, 1'b0);
    cyc = 1;
    while (!done_o && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 2) begin failures++; $display("FAIL rol_latency got=%0d exp=2", cyc); end
    checks++; if ({rslt_o, sc_o} !== {8'h03, 1'b1}) begin
      failures++; $display("FAIL rol_rslt got=%h/%b exp=03/1", rslt_o, sc_o);
    end
    issue(ROR, 8'h81, 8'h0B, 1'b1);
    cyc = 1;
    while (!done_o && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 4) begin failures++; $display("FAIL ror_latency got=%0d exp=4", cyc); end
    checks++; if ({rslt_o, sc_o, pari_o} !== {8'h30, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ror_rslt got=%h/%b/%b exp=30/0/0", rslt_o, sc_o, pari_o);
    end
  endtask

  task automatic test_sub();
    issue(SUB, 8'h05, 8'h05, 1'b1);
    checks++; if ({done_o, rslt_o, zero_o, sc_o, neq_o} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sub_equal got=%b/%h/%b%b%b exp=1/00/100", done_o, rslt_o, zero_o, sc_o, neq_o);
    end
    @(negedge clk);
    issue(SUB, 8'h03, 8'h05, 1'b0);
    checks++; if ({done_o, rslt_o, sc_o, pari_o, zero_o, neq_o} !== {1'b1, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sub_borrow got=%b/%h/%b%b%b%b exp=1/fe/1101", done_o, rslt_o, sc_o, pari_o, zero_o, neq_o);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    issue(ROR, 8'h81, 8'h03, 1'b0);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy_o); end
    issue(XOR, 8'hFF, 8'h0F, 1'b1);
    cyc = 2;
    while (!done_o && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 4) begin failures++; $display("FAIL ign_latency got=%0d exp=4", cyc); end
    checks++; if ({rslt_o, sc_o} !== {8'h30, 1'b0}) begin
      failures++; $display("FAIL ign_rslt got=%h/%b exp=30/0", rslt_o, sc_o);
    end
    @(negedge clk);
    checks++; if ({done_o, busy_o} !== 2'b00) begin failures++; $display("FAIL ign_idle got=%b exp=00", {done_o, busy_o}); end
  endtask

  task automatic test_back_to_back();
    issue(ADD, 8'h01, 8'h02, 1'b0);
    checks++; if ({done_o, rslt_o} !== {1'b1, 8'h03}) begin
      failures++; $display("FAIL b2b_first got=%b/%h exp=1/03", done_o, rslt_o);
    end
    issue(XOR, 8'hF0, 8'h0F, 1'b0);
    checks++; if ({done_o, rslt_o, pari_o, neq_o, sc_o} !== {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL b2b_second got=%b/%h/%b%b%b exp=1/ff/010", done_o, rslt_o, pari_o, neq_o, sc_o);
    end
    issue(NAND, 8'hF0, 8'hFF, 1'b0);
    checks++; if ({done_o, rslt_o} !== {1'b1, 8'h0F}) begin
      failures++; $display("FAIL b2b_nand got=%b/%h exp=1/0f", done_o, rslt_o);
    end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", done_o); end
  endtask

  task automatic test_shift_k0();
    issue(ROR, 8'h5A, 8'h08, 1'b1);
    checks++; if ({done_o, rslt_o, sc_o} !== {1'b1, 8'h5A, 1'b0}) begin
      failures++; $display("FAIL ror_k0 got=%b/%h/%b exp=1/5a/0", done_o, rslt_o, sc_o);
    end
    @(negedge clk);
    issue(LSR, 8'h00, 8'h10, 1'b1);
    checks++; if ({done_o, rslt_o, sc_o, zero_o, neq_o} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      failures++; $display("FAIL lsr_k0 got=%b/%h/%b%b%b exp=1/00/111", done_o, rslt_o, sc_o, zero_o, neq_o);
    end
    @(negedge clk);
    issue(PASS, 8'hC5, 8'hC5, 1'b1);
    checks++; if ({rslt_o, sc_o, pari_o, neq_o} !== {8'hC5, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL pass got=%h/%b%b%b exp=c5/000", rslt_o, sc_o, pari_o, neq_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int cyc; logic done_seen;
    issue(LSR, 8'hFF, 8'h07, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if ({rslt_o, busy_o, done_o, sc_o, zero_o, pari_o, neq_o} !== 14'b0) begin
      failures++; $display("FAIL rst_mid got=%h/%b exp=00/000000", rslt_o, {busy_o, done_o, sc_o, zero_o, pari_o, neq_o});
    end
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin done_seen |= done_o | busy_o; @(negedge clk); end
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL rst_abort got=%b exp=0", done_seen); end
    issue(ADD, 8'h01, 8'h01, 1'b0);
    cyc = 1;
    while (!done_o && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if ({cyc[7:0], rslt_o, sc_o} !== {8'd1, 8'h02, 1'b0}) begin
      failures++; $display("FAIL rst_recover got=%0d/%h/%b exp=1/02/0", cyc, rslt_o, sc_o);
    end
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; cmd_i = NAND; a_i = '0; b_i = '0; sc_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_lsr();
    test_rotate();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_shift_k0();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
